// File: rtl/instr_register_resp.sv
// instr_register_resp: 32-entry instruction register stack with a registered
// read port. Every write stores {opcode, operand_a, operand_b, rez}; rez is
// computed from the write-port inputs in the same cycle. Reads take one cycle,
// flag never-written and divide-by-zero entries on rd_err, and see the contents
// from before a same-edge write to the same address.
// Optional feature: define INSTR_REGISTER_RESP_DIV_EN to build the DIV/MOD
// divider. Without it, DIV/MOD store rez=0 and never flag divide-by-zero.

package instr_register_resp_pkg;

  typedef logic [4:0] address_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rez;
  } instruction_t;

endpackage

module instr_register_resp
  import instr_register_resp_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  address_t     write_pointer,
  input  opcode_t      opcode,
  input  operand_t     operand_a,
  input  operand_t     operand_b,
  input  logic         rd_en,
  input  address_t     read_pointer,
  output instruction_t instruction_word,
  output logic         rd_valid,
  output logic         rd_err,
  output logic [5:0]   fill_count
);

  // Storage and per-location status.
  instruction_t                 stack_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]       written_q, written_d;
  logic [NUM_ENTRIES-1:0]       divzero_q, divzero_d;
  logic [5:0]                   fill_count_q, fill_count_d;

  // Registered read port.
  instruction_t                 instruction_word_q, instruction_word_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         rd_err_q, rd_err_d;

  // Write-side datapath.
  result_t                      a_ext;
  result_t                      b_ext;
  result_t                      rez_calc;
  logic                         div_zero;
  instruction_t                 wr_entry;

  assign a_ext = {{32{operand_a[31]}}, operand_a};
  assign b_ext = {{32{operand_b[31]}}, operand_b};

  // Compute the 64-bit result for the instruction being written.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    rez_calc = '0;
    div_zero = 1'b0;
    case (opcode)
      ZERO:  rez_calc = '0;
      PASSA: rez_calc = a_ext;
      PASSB: rez_calc = b_ext;
      ADD:   rez_calc = a_ext + b_ext;
      SUB:   rez_calc = a_ext - b_ext;
      MULT:  rez_calc = a_ext * b_ext;
`ifdef INSTR_REGISTER_RESP_DIV_EN
      DIV: begin
        if (b_ext == '0) div_zero = 1'b1;
        else             rez_calc = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == '0) div_zero = 1'b1;
        else             rez_calc = a_ext % b_ext;
      end
`else
      DIV:   rez_calc = '0;
      MOD:   rez_calc = '0;
`endif
      default: rez_calc = '0;
    endcase
  end

  // Assemble the entry that a write stores.
  always_comb begin
    wr_entry      = '0;
    wr_entry.opc  = opcode;
    wr_entry.op_a = operand_a;
    wr_entry.op_b = operand_b;
    wr_entry.rez  = rez_calc;
  end

  // Next-state for the written/divzero bits and the distinct-location count.
  always_comb begin
    written_d    = written_q;
    divzero_d    = divzero_q;
    fill_count_d = fill_count_q;
    if (load_en) begin
      if (!written_q[write_pointer] && (fill_count_q < 6'(NUM_ENTRIES)))
        fill_count_d = fill_count_q + 6'd1;
      written_d[write_pointer] = 1'b1;
      divzero_d[write_pointer] = div_zero;
    end
  end

  // Read port next-state: sample pre-write contents, flag bad entries.
  always_comb begin
    instruction_word_d = instruction_word_q;
    rd_valid_d         = 1'b0;
    rd_err_d           = 1'b0;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (written_q[read_pointer]) begin
        instruction_word_d = stack_q[read_pointer];
        rd_err_d           = divzero_q[read_pointer];
      end else begin
        instruction_word_d = '0;
        rd_err_d           = 1'b1;
      end
    end
  end

  // Stack array write.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; the written bits mask stale contents,
    // and leaving it out lets the array map onto plain RAM.
    if (load_en) stack_q[write_pointer] <= wr_entry;
  end

  // Control state and read outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments here so every flop samples its _d value
    // from before this edge, independent of statement order.
    if (reset) begin
      written_q          <= '0;
      divzero_q          <= '0;
      fill_count_q       <= '0;
      instruction_word_q <= '0;
      rd_valid_q         <= 1'b0;
      rd_err_q           <= 1'b0;
    end else begin
      written_q          <= written_d;
      divzero_q          <= divzero_d;
      fill_count_q       <= fill_count_d;
      instruction_word_q <= instruction_word_d;
      rd_valid_q         <= rd_valid_d;
      rd_err_q           <= rd_err_d;
    end
  end

  assign instruction_word = instruction_word_q;
  assign rd_valid         = rd_valid_q;
  assign rd_err           = rd_err_q;
  assign fill_count       = fill_count_q;

endmodule

// File: tb/tb_instr_register_resp.sv
// Self-checking bench for instr_register_resp: directed scenarios with literal
// expectations plus randomized traffic against a behavioural stack model.
// Expectations for DIV/MOD follow INSTR_REGISTER_RESP_DIV_EN when it is defined.

module tb_instr_register_resp;
  import instr_register_resp_pkg::*;

`ifdef INSTR_REGISTER_RESP_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         load_en;
  address_t     write_pointer;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  logic         rd_en;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         rd_valid;
  logic         rd_err;
  logic [5:0]   fill_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what each address holds and what the read port shows.
  instruction_t mem_m     [32];
  bit           written_m [32];
  bit           dz_m      [32];
  int           fill_m;
  instruction_t exp_word;
  bit           exp_valid;
  bit           exp_err;

  instr_register_resp dut (
    .clk              (clk),
    .reset            (reset),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .rd_en            (rd_en),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid),
    .rd_err           (rd_err),
    .fill_count       (fill_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Arithmetic meaning of each opcode, worked out in 64-bit integers.
  function automatic longint model_rez(input opcode_t op, input int a, input int b,
                                       output bit dz);
    longint r;
    r  = 0;
    dz = 1'b0;
    case (op)
      PASSA: r = longint'(a);
      PASSB: r = longint'(b);
      ADD:   r = longint'(a) + longint'(b);
      SUB:   r = longint'(a) - longint'(b);
      MULT:  r = longint'(a) * longint'(b);
      DIV: if (DIV_EN) begin
             if (b == 0) dz = 1'b1;
             else        r = longint'(a) / longint'(b);
           end
      MOD: if (DIV_EN) begin
             if (b == 0) dz = 1'b1;
             else        r = longint'(a) % longint'(b);
           end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int rand_operand();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 32'sh7fff_ffff;
      2:       return int'(32'h8000_0000);
      3:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom);
    endcase
  endfunction

  // Clear the model and hold reset across one rising edge.
  task automatic apply_reset();
    reset   = 1'b1;
    load_en = 1'b0;
    rd_en   = 1'b0;
    write_pointer = '0;
    read_pointer  = '0;
    opcode    = ZERO;
    operand_a = '0;
    operand_b = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      written_m[i] = 1'b0;
      dz_m[i]      = 1'b0;
    end
    fill_m    = 0;
    exp_word  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Drive one cycle of traffic and advance the model; returns 1 ns after the edge.
  task automatic step(input bit ld, input address_t wp, input opcode_t op,
                      input int a, input int b, input bit rd, input address_t rp);
    longint r;
    bit     dz;
    load_en = ld;   write_pointer = wp; opcode = op;
    operand_a = a;  operand_b = b;
    rd_en = rd;     read_pointer = rp;
    // Read sees the contents from before this edge's write.
    exp_valid = rd;
    exp_err   = 1'b0;
    if (rd) begin
      if (written_m[rp]) begin
        exp_word = mem_m[rp];
        exp_err  = dz_m[rp];
      end else begin
        exp_word = '0;
        exp_err  = 1'b1;
      end
    end
    if (ld) begin
      r = model_rez(op, a, b, dz);
      mem_m[wp].opc  = op;
      mem_m[wp].op_a = a;
      mem_m[wp].op_b = b;
      mem_m[wp].rez  = r;
      dz_m[wp] = dz;
      if (!written_m[wp]) fill_m++;
      written_m[wp] = 1'b1;
    end
    @(posedge clk);
    #1;
    load_en = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rd_valid, rd_err, fill_count} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%0b err=%0b fill=%0d, want 0 0 0", rd_valid, rd_err, fill_count);
    end
    checks++;
    if (instruction_word !== '0) begin
      errors++;
      $display("FAIL reset_word: got %h want 0", instruction_word);
    end
  endtask

  task automatic test_add();
    apply_reset();
    step(1, 5'd3, ADD, 7, -5, 0, 5'd0);
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd3);
    checks++;
    if (instruction_word.opc !== ADD || instruction_word.op_a !== 32'sd7 ||
        instruction_word.op_b !== -32'sd5 || instruction_word.rez !== 64'sd2) begin
      errors++;
      $display("FAIL add_word: got %h", instruction_word);
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_err !== 1'b0 || fill_count !== 6'd1) begin
      errors++;
      $display("FAIL add_flags: valid=%0b err=%0b fill=%0d, want 1 0 1", rd_valid, rd_err, fill_count);
    end
  endtask

  task automatic test_mult_sub();
    apply_reset();
    step(1, 5'd0,  MULT, -15, 15, 0, 5'd0);
    step(1, 5'd31, SUB,  0,   15, 0, 5'd0);
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd0);
    checks++;
    if (instruction_word.rez !== -64'sd225 || instruction_word.opc !== MULT || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL mult_loc0: rez=%0d opc=%0d err=%0b, want -225 MULT 0",
               instruction_word.rez, instruction_word.opc, rd_err);
    end
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd31);
    checks++;
    if (instruction_word.rez !== -64'sd15 || fill_count !== 6'd2) begin
      errors++;
      $display("FAIL sub_loc31: rez=%0d fill=%0d, want -15 2", instruction_word.rez, fill_count);
    end
  endtask

  task automatic test_divzero();
    logic exp_e;
    apply_reset();
    exp_e = DIV_EN ? 1'b1 : 1'b0;
    step(1, 5'd5, DIV, 9, 0, 0, 5'd0);
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd5);
    checks++;
    if (instruction_word.rez !== 64'sd0 || rd_err !== exp_e || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL div_by_zero: rez=%0d err=%0b valid=%0b, want 0 %0b 1",
               instruction_word.rez, rd_err, rd_valid, exp_e);
    end
    step(1, 5'd5, MOD, 9, 4, 0, 5'd0);
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd5);
    checks++;
    if (instruction_word.rez !== (DIV_EN ? 64'sd1 : 64'sd0) || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL mod_rewrite: rez=%0d err=%0b, want %0d 0",
               instruction_word.rez, rd_err, DIV_EN ? 1 : 0);
    end
  endtask

  task automatic test_read_before_write();
    apply_reset();
    step(1, 5'd7, PASSB, 0, 4, 0, 5'd0);
    step(1, 5'd7, PASSA, 1, 0, 1, 5'd7);
    checks++;
    if (instruction_word.opc !== PASSB || instruction_word.rez !== 64'sd4) begin
      errors++;
      $display("FAIL rbw_same_edge: opc=%0d rez=%0d, want PASSB 4", instruction_word.opc, instruction_word.rez);
    end
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd7);
    checks++;
    if (instruction_word.opc !== PASSA || instruction_word.rez !== 64'sd1) begin
      errors++;
      $display("FAIL rbw_after: opc=%0d rez=%0d, want PASSA 1", instruction_word.opc, instruction_word.rez);
    end
  endtask

  task automatic test_unwritten_and_fill();
    apply_reset();
    step(1, 5'd3, ADD, 1, 2, 0, 5'd0);
    step(1, 5'd3, SUB, 1, 2, 1, 5'd20);
    checks++;
    if (instruction_word !== '0 || rd_valid !== 1'b1 || rd_err !== 1'b1) begin
      errors++;
      $display("FAIL unwritten_read: word=%h valid=%0b err=%0b, want 0 1 1", instruction_word, rd_valid, rd_err);
    end
    checks++;
    if (fill_count !== 6'd1) begin
      errors++;
      $display("FAIL overwrite_fill: got %0d want 1", fill_count);
    end
    // Idle cycle: valid drops, err drops, word holds.
    step(0, 5'd0, ZERO, 0, 0, 0, 5'd0);
    checks++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || instruction_word !== exp_word) begin
      errors++;
      $display("FAIL idle_hold: valid=%0b err=%0b word=%h", rd_valid, rd_err, instruction_word);
    end
  endtask

  task automatic test_fill_saturate();
    apply_reset();
    for (int i = 0; i < 32; i++)
      step(1, address_t'(i), opcode_t'($urandom_range(0, 7)), rand_operand(), rand_operand(), 0, 5'd0);
    checks++;
    if (fill_count !== 6'd32) begin
      errors++;
      $display("FAIL fill_all: got %0d want 32", fill_count);
    end
    for (int i = 0; i < 4; i++)
      step(1, address_t'($urandom_range(0, 31)), ADD, rand_operand(), rand_operand(), 1, 5'd31);
    checks++;
    if (fill_count !== 6'd32 || instruction_word !== exp_word) begin
      errors++;
      $display("FAIL fill_saturate: fill=%0d word=%h want 32 %h", fill_count, instruction_word, exp_word);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    step(1, 5'd2, ADD, 3, 4, 0, 5'd0);
    step(1, 5'd9, MULT, 6, 7, 1, 5'd2);
    // Assert reset between edges with a write and read pending.
    #2;
    load_en = 1'b1; write_pointer = 5'd11; opcode = PASSA; operand_a = 99;
    rd_en = 1'b1;   read_pointer = 5'd9;
    reset = 1'b1;
    #1;
    checks++;
    if ({rd_valid, rd_err, fill_count} !== 8'b0 || instruction_word !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: valid=%0b err=%0b fill=%0d word=%h", rd_valid, rd_err, fill_count, instruction_word);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; load_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      written_m[i] = 1'b0;
      dz_m[i]      = 1'b0;
    end
    fill_m = 0; exp_word = '0; exp_valid = 1'b0; exp_err = 1'b0;
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd2);
    checks++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b1 || instruction_word !== '0 || fill_count !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset_read: err=%0b valid=%0b word=%h fill=%0d, want 1 1 0 0",
               rd_err, rd_valid, instruction_word, fill_count);
    end
    step(0, 5'd0, ZERO, 0, 0, 1, 5'd11);
    checks++;
    if (rd_err !== 1'b1 || fill_count !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset_discard: err=%0b fill=%0d, want 1 0", rd_err, fill_count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 60, address_t'($urandom_range(0, 31)),
           opcode_t'($urandom_range(0, 7)), rand_operand(), rand_operand(),
           $urandom_range(0, 99) < 70, address_t'($urandom_range(0, 31)));
      checks++;
      if ({rd_valid, rd_err, instruction_word, fill_count} !==
          {exp_valid, exp_err, exp_word, 6'(fill_m)}) begin
        errors++;
        $display("FAIL random_%0d: got v=%0b e=%0b w=%h f=%0d want v=%0b e=%0b w=%h f=%0d", n,
                 rd_valid, rd_err, instruction_word, fill_count,
                 exp_valid, exp_err, exp_word, fill_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult_sub();
    test_divzero();
    test_read_before_write();
    test_unwritten_and_fill();
    test_fill_saturate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
